// File: rtl/core_ctrl.sv
// rtl/core_ctrl.sv - autonomous weight-load/execute/drain sequencer driving the core inst bus
module core_ctrl #(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int ADDR_W   = 11,
  parameter int KIJ_W    = 4,
  parameter int OF_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              acc_mode,
  input  logic [ADDR_W-1:0] cfg_act_base,
  input  logic [ADDR_W-1:0] cfg_wt_base,
  input  logic [ADDR_W-1:0] cfg_psum_base,
  input  logic [ADDR_W-1:0] cfg_n_act,
  input  logic [KIJ_W-1:0]  cfg_n_kij,
  input  logic              l0_full,
  input  logic              l0_empty,
  input  logic              ofifo_valid,
  output logic [33:0]       inst,
  output logic              busy,
  output logic              done
);

  // Counters only ever need to reach max(COL, ROW, n_act), and n_act is bounded by the OFIFO depth.
  localparam int CNT_W = $clog2(OF_DEPTH + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_WT_RD, S_WT_LD, S_WT_GAP, S_ACT, S_DRAIN, S_DONE
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt_a;      // reads issued (xmem or OFIFO) in the current phase
  logic [CNT_W-1:0]  cnt_b;      // l0_wr / load / gap / execute / pmem-write progress
  logic [CNT_W-1:0]  n_act_q;
  logic [KIJ_W-1:0]  kij;
  logic [KIJ_W-1:0]  n_kij_q;
  logic [ADDR_W-1:0] act_base_q;
  logic [ADDR_W-1:0] psum_base_q;
  logic [ADDR_W-1:0] wt_ptr;     // weight base of the current kij, stepped by COL
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] wr_addr;
  logic              acc_mode_q;
  logic              rd_pend;    // xmem read issued last cycle, data lands in L0 now
  logic              wr_pend;    // OFIFO row popped last cycle, write it to pmem now
  logic              rd_go;
  logic              ex_go;
  logic              of_go;

  logic              acc_r, cen_p, wen_p, cen_x, wen_x;
  logic [ADDR_W-1:0] a_p, a_x;
  logic              ofifo_rd_r, l0_rd_r, l0_wr_r, exec_r, load_r;

  assign inst = {acc_r, cen_p, wen_p, a_p, cen_x, wen_x, a_x,
                 ofifo_rd_r, 1'b0, 1'b0, l0_rd_r, l0_wr_r, exec_r, load_r};
  assign busy = (state != S_IDLE);

  // Per-cycle issue decisions: xmem reads, executes and OFIFO pops stall independently.
  always_comb begin
    rd_go = 1'b0;
    ex_go = 1'b0;
    of_go = 1'b0;
    case (state)
      S_WT_RD: rd_go = !l0_full && (cnt_a < CNT_W'(COL));
      S_ACT: begin
        rd_go = !l0_full && (cnt_a < n_act_q);
        ex_go = !l0_empty && (cnt_b < n_act_q);
      end
      S_DRAIN: of_go = ofifo_valid && (cnt_a < n_act_q);
      default: ;
    endcase
  end

  // Sequencer FSM; the bus returns to its idle value each cycle unless a field is driven below.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      cnt_a       <= '0;
      cnt_b       <= '0;
      n_act_q     <= '0;
      kij         <= '0;
      n_kij_q     <= '0;
      act_base_q  <= '0;
      psum_base_q <= '0;
      wt_ptr      <= '0;
      rd_addr     <= '0;
      wr_addr     <= '0;
      acc_mode_q  <= 1'b0;
      rd_pend     <= 1'b0;
      wr_pend     <= 1'b0;
      done        <= 1'b0;
      acc_r       <= 1'b0;
      cen_p       <= 1'b1;
      wen_p       <= 1'b1;
      a_p         <= '0;
      cen_x       <= 1'b1;
      wen_x       <= 1'b1;
      a_x         <= '0;
      ofifo_rd_r  <= 1'b0;
      l0_rd_r     <= 1'b0;
      l0_wr_r     <= 1'b0;
      exec_r      <= 1'b0;
      load_r      <= 1'b0;
    end else begin
      acc_r      <= 1'b0;
      cen_p      <= 1'b1;
      wen_p      <= 1'b1;
      a_p        <= '0;
      cen_x      <= 1'b1;
      wen_x      <= 1'b1;
      a_x        <= '0;
      ofifo_rd_r <= 1'b0;
      l0_rd_r    <= 1'b0;
      l0_wr_r    <= rd_pend;
      exec_r     <= 1'b0;
      load_r     <= 1'b0;
      rd_pend    <= rd_go;
      wr_pend    <= of_go;
      done       <= 1'b0;

      if (rd_go) begin
        cen_x   <= 1'b0;
        a_x     <= rd_addr;
        rd_addr <= rd_addr + ADDR_W'(1);
        cnt_a   <= cnt_a + CNT_W'(1);
      end
      if (ex_go) begin
        l0_rd_r <= 1'b1;
        exec_r  <= 1'b1;
      end
      if (of_go) begin
        ofifo_rd_r <= 1'b1;
        cnt_a      <= cnt_a + CNT_W'(1);
      end
      if (wr_pend) begin
        cen_p   <= 1'b0;
        wen_p   <= 1'b0;
        a_p     <= wr_addr;
        acc_r   <= acc_mode_q && (kij != '0);
        wr_addr <= wr_addr + ADDR_W'(1);
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            n_act_q     <= CNT_W'(cfg_n_act);
            n_kij_q     <= cfg_n_kij;
            act_base_q  <= cfg_act_base;
            psum_base_q <= cfg_psum_base;
            acc_mode_q  <= acc_mode;
            wt_ptr      <= cfg_wt_base;
            rd_addr     <= cfg_wt_base;
            kij         <= '0;
            cnt_a       <= '0;
            cnt_b       <= '0;
            if (cfg_n_act == '0 || cfg_n_kij == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_WT_RD;
            end
          end
        end
        S_WT_RD: begin
          if (rd_pend) begin
            if (cnt_b == CNT_W'(COL - 1)) begin
              state <= S_WT_LD;
              cnt_b <= '0;
            end else begin
              cnt_b <= cnt_b + CNT_W'(1);
            end
          end
        end
        S_WT_LD: begin
          if (!l0_empty) begin
            l0_rd_r <= 1'b1;
            load_r  <= 1'b1;
            if (cnt_b == CNT_W'(COL - 1)) begin
              state <= S_WT_GAP;
              cnt_b <= '0;
            end else begin
              cnt_b <= cnt_b + CNT_W'(1);
            end
          end
        end
        S_WT_GAP: begin
          if (cnt_b == CNT_W'(ROW - 1)) begin
            state   <= S_ACT;
            cnt_a   <= '0;
            cnt_b   <= '0;
            rd_addr <= act_base_q;
          end else begin
            cnt_b <= cnt_b + CNT_W'(1);
          end
        end
        S_ACT: begin
          if (ex_go) begin
            if (cnt_b == n_act_q - CNT_W'(1)) begin
              state   <= S_DRAIN;
              cnt_a   <= '0;
              cnt_b   <= '0;
              wr_addr <= psum_base_q;
            end else begin
              cnt_b <= cnt_b + CNT_W'(1);
            end
          end
        end
        S_DRAIN: begin
          if (wr_pend) begin
            if (cnt_b == n_act_q - CNT_W'(1)) begin
              kij     <= kij + KIJ_W'(1);
              wt_ptr  <= wt_ptr + ADDR_W'(COL);
              rd_addr <= wt_ptr + ADDR_W'(COL);
              cnt_a   <= '0;
              cnt_b   <= '0;
              if (kij + KIJ_W'(1) == n_kij_q) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_WT_RD;
              end
            end else begin
              cnt_b <= cnt_b + CNT_W'(1);
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_ctrl.sv
// tb/tb_core_ctrl.sv - directed self-checking bench for core_ctrl
`timescale 1ns/1ps
module tb_core_ctrl;

  localparam logic [33:0] INST_IDLE = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        acc_mode = 1'b0;
  logic [10:0] cfg_act_base = '0;
  logic [10:0] cfg_wt_base = '0;
  logic [10:0] cfg_psum_base = '0;
  logic [10:0] cfg_n_act = '0;
  logic [3:0]  cfg_n_kij = '0;
  logic        l0_full = 1'b0;
  logic        l0_empty = 1'b0;
  logic        ofifo_valid = 1'b1;
  logic [33:0] inst;
  logic        busy;
  logic        done;

  int cyc = 0;
  int total = 0;
  int passes = 0;
  int start_cyc = 0;
  int lat;
  int bad_fixed = 0;
  int bx, bp, blw, bld, bex, bof, bdn;
  bit seen_ex;

  int xa[$], xc[$], pa[$], pk[$], pc[$], lw_c[$], ld_c[$], ex_c[$], of_c[$], dn_c[$];

  always #5 clk = ~clk;

  core_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .acc_mode     (acc_mode),
    .cfg_act_base (cfg_act_base),
    .cfg_wt_base  (cfg_wt_base),
    .cfg_psum_base(cfg_psum_base),
    .cfg_n_act    (cfg_n_act),
    .cfg_n_kij    (cfg_n_kij),
    .l0_full      (l0_full),
    .l0_empty     (l0_empty),
    .ofifo_valid  (ofifo_valid),
    .inst         (inst),
    .busy         (busy),
    .done         (done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor, sampled mid-cycle while out of reset.
  always @(negedge clk) begin
    if (reset) begin
      if (!inst[19]) begin xa.push_back(int'(inst[17:7])); xc.push_back(cyc); end
      if (!inst[32]) begin pa.push_back(int'(inst[30:20])); pk.push_back(int'(inst[33])); pc.push_back(cyc); end
      if (inst[2]) lw_c.push_back(cyc);
      if (inst[0]) ld_c.push_back(cyc);
      if (inst[1]) ex_c.push_back(cyc);
      if (inst[6]) of_c.push_back(cyc);
      if (done) dn_c.push_back(cyc);
      if (inst[5] || inst[4] || (!inst[19] && !inst[18]) || (!inst[32] && inst[31])) bad_fixed <= bad_fixed + 1;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
  endtask

  task automatic chk_idle(input string tag);
    total++;
    assert (inst === INST_IDLE) passes++;
    else $error("FAIL %s: observed %h, expected %h", tag, inst, INST_IDLE);
  endtask

  function automatic int qat(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic snap();
    bx = xa.size(); bp = pa.size(); blw = lw_c.size(); bld = ld_c.size();
    bex = ex_c.size(); bof = of_c.size(); bdn = dn_c.size();
  endtask

  task automatic start_run(input logic [10:0] wt, input logic [10:0] act, input logic [10:0] psum,
                           input logic [10:0] nact, input logic [3:0] nk, input logic am);
    @(negedge clk);
    cfg_wt_base = wt; cfg_act_base = act; cfg_psum_base = psum;
    cfg_n_act = nact; cfg_n_kij = nk; acc_mode = am;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_done(input string tag, input int budget, input bit pat, output int l);
    int k;
    bit seen;
    k = 0;
    seen = 1'b0;
    l = -1;
    for (int i = 0; i < budget && !seen; i++) begin
      if (done) begin
        seen = 1'b1;
        l = cyc - start_cyc;
      end else begin
        @(negedge clk);
        if (pat) ofifo_valid = (k % 3 == 0);
        k++;
      end
    end
    chk({tag, " done seen"}, int'(seen), 1);
    ofifo_valid = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_idle("reset inst");
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_idle("idle inst");

    // Single kij
    snap();
    start_run(11'h100, 11'h000, 11'h200, 11'd4, 4'd1, 1'b0);
    wait_done("t2", 200, 1'b0, lat);
    chk("t2 latency", lat, 34);
    chk("t2 xmem reads", xa.size() - bx, 12);
    for (int i = 0; i < 8; i++) chk($sformatf("t2 wt addr %0d", i), qat(xa, bx + i), 32'h100 + i);
    for (int j = 0; j < 4; j++) chk($sformatf("t2 act addr %0d", j), qat(xa, bx + 8 + j), j);
    chk("t2 first read cycle", qat(xc, bx) - start_cyc, 1);
    chk("t2 l0_wr count", lw_c.size() - blw, 12);
    chk("t2 load count", ld_c.size() - bld, 8);
    chk("t2 load span", qat(ld_c, bld + 7) - qat(ld_c, bld), 7);
    chk("t2 gap", qat(ex_c, bex) - qat(ld_c, bld + 7), 9);
    chk("t2 exec count", ex_c.size() - bex, 4);
    chk("t2 ofifo_rd count", of_c.size() - bof, 4);
    chk("t2 pmem writes", pa.size() - bp, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t2 psum addr %0d", j), qat(pa, bp + j), 32'h200 + j);
      chk($sformatf("t2 acc %0d", j), qat(pk, bp + j), 0);
    end
    chk("t2 done pulses", dn_c.size() - bdn, 1);
    chk("t2 busy after", int'(busy), 0);

    // Accumulate across three kij
    snap();
    start_run(11'h100, 11'h040, 11'h300, 11'd2, 4'd3, 1'b1);
    wait_done("t3", 400, 1'b0, lat);
    chk("t3 latency", lat, 90);
    chk("t3 xmem reads", xa.size() - bx, 30);
    chk("t3 kij0 act addr", qat(xa, bx + 8), 32'h040);
    chk("t3 kij1 wt addr", qat(xa, bx + 10), 32'h108);
    chk("t3 kij2 wt first", qat(xa, bx + 20), 32'h110);
    chk("t3 kij2 wt last", qat(xa, bx + 27), 32'h117);
    chk("t3 pmem writes", pa.size() - bp, 6);
    for (int j = 0; j < 6; j++) begin
      chk($sformatf("t3 psum addr %0d", j), qat(pa, bp + j), 32'h300 + (j % 2));
      chk($sformatf("t3 acc %0d", j), qat(pk, bp + j), (j >= 2) ? 1 : 0);
    end

    // Backpressure during weight reads, with address wrap
    snap();
    start_run(11'h7FC, 11'h010, 11'h200, 11'd2, 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    l0_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("t4 no read while full %0d", i), int'(inst[19]), 1);
    end
    l0_full = 1'b0;
    wait_done("t4", 200, 1'b0, lat);
    chk("t4 latency", lat, 35);
    chk("t4 resume cycle", qat(xc, bx + 2) - start_cyc, 8);
    chk("t4 xmem reads", xa.size() - bx, 10);
    for (int i = 0; i < 8; i++) chk($sformatf("t4 wt addr %0d", i), qat(xa, bx + i), (32'h7FC + i) & 32'h7FF);
    chk("t4 l0_wr count", lw_c.size() - blw, 10);

    // Drain stall
    snap();
    start_run(11'h100, 11'h000, 11'h200, 11'd4, 4'd1, 1'b0);
    wait_done("t5", 300, 1'b1, lat);
    chk("t5 ofifo_rd count", of_c.size() - bof, 4);
    chk("t5 pmem writes", pa.size() - bp, 4);
    for (int j = 0; j < 4; j++) begin
      chk($sformatf("t5 psum addr %0d", j), qat(pa, bp + j), 32'h200 + j);
      chk($sformatf("t5 write follows pop %0d", j), qat(pc, bp + j) - qat(of_c, bof + j), 1);
    end

    // Zero-length configs
    snap();
    start_run(11'h100, 11'h000, 11'h200, 11'd0, 4'd2, 1'b0);
    wait_done("t6 nact0", 5, 1'b0, lat);
    chk("t6 nact0 latency", lat, 0);
    start_run(11'h100, 11'h000, 11'h200, 11'd4, 4'd0, 1'b0);
    wait_done("t6 nkij0", 5, 1'b0, lat);
    chk("t6 nkij0 latency", lat, 0);
    chk("t6 zero xmem reads", xa.size() - bx, 0);
    chk("t6 zero pmem writes", pa.size() - bp, 0);
    chk("t6 zero l0_wr", lw_c.size() - blw, 0);
    chk("t6 zero done pulses", dn_c.size() - bdn, 2);

    // Start while busy is ignored
    snap();
    start_run(11'h100, 11'h000, 11'h250, 11'd2, 4'd1, 1'b0);
    repeat (3) @(negedge clk);
    cfg_psum_base = 11'h3F0; cfg_n_act = 11'd5; cfg_n_kij = 4'd2; cfg_wt_base = 11'h500;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("t6 busy", 200, 1'b0, lat);
    chk("t6 busy latency", lat, 30);
    repeat (40) @(negedge clk);
    chk("t6 busy pmem writes", pa.size() - bp, 2);
    chk("t6 busy psum0", qat(pa, bp), 32'h250);
    chk("t6 busy psum1", qat(pa, bp + 1), 32'h251);
    chk("t6 busy wt addr", qat(xa, bx + 7), 32'h107);
    chk("t6 busy done pulses", dn_c.size() - bdn, 1);
    chk("t6 busy idle", int'(busy), 0);

    // Reset in the middle of ACT
    snap();
    start_run(11'h100, 11'h000, 11'h200, 11'd4, 4'd1, 1'b0);
    seen_ex = 1'b0;
    for (int i = 0; i < 100 && !seen_ex; i++) begin
      @(negedge clk);
      if (inst[1]) seen_ex = 1'b1;
    end
    chk("t1 reached act", int'(seen_ex), 1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("t1 inst on reset");
    chk("t1 busy on reset", int'(busy), 0);
    @(negedge clk);
    reset = 1'b1;
    snap();
    repeat (20) @(negedge clk);
    chk("t1 busy after release", int'(busy), 0);
    chk("t1 no reads after release", xa.size() - bx, 0);
    chk_idle("t1 inst after release");

    chk("fixed fields", bad_fixed, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
